demux_4: RTL
============

Name: demux_4

Overview:
- 1-to-4 registered demultiplexer with valid/ready handshake; the inverse of the datapath's registered 4:1 mux.
- Steers one 16-bit input word to one of four output channels A–D, or to all four in broadcast mode.
- Each output channel has a one-entry holding register, so a stalled consumer blocks only its own channel.
- Sits between a single producer and four consumers on the same 16-bit bus.

Parameters:
- WIDTH, 16, data width. Bus bit ordering is [0:WIDTH-1], bit 0 is MSB.
- CNT_W, 16, width of the accepted-word counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_data  input  WIDTH  word to route.
- in_valid  input  1  in_data/select/bcast are valid this cycle.
- select  input  2  target channel: 00=A, 01=B, 10=C, 11=D.
- bcast  input  1  1 = write word to all four channels; select is ignored.
- in_ready  output  1  block accepts the word this cycle.
- out_A, out_B, out_C, out_D  output  WIDTH  channel data.
- valid_A, valid_B, valid_C, valid_D  output  1  channel holds a word.
- ready_A, ready_B, ready_C, ready_D  input  1  consumer takes the channel word this cycle.
- xfer_count  output  CNT_W  number of accepted input words.

Behaviour:
- Per channel k: state full_k and data_k. valid_k = full_k; out_k = data_k.
- can_take_k = !full_k || ready_k. A draining slot may be refilled in the same cycle.
- in_ready (combinational):
  - 0 while rst = 1.
  - Otherwise, if bcast = 1: AND of can_take over all four channels.
  - Otherwise: can_take of the channel given by select.
- Accept = in_valid && in_ready.
- On accept: every target channel loads data_k <= in_data and full_k <= 1 at the next edge.
- For each non-targeted channel: if full_k && ready_k, then full_k <= 0; data_k is unchanged.
- Latency: a word accepted in cycle N appears on out_k with valid_k = 1 in cycle N+1.
- When full_k = 1 and ready_k = 0, out_k holds stable until the transfer completes.
- select, bcast and in_data are don't-care when in_valid = 0. When in_valid = 0, in_ready is still driven as defined above.
- Broadcast is all-or-nothing: no channel loads unless all four can take the word.
- Simultaneous drain and refill on a channel: the new word wins, and valid_k stays 1 with no bubble.
- xfer_count increments by 1 per accept; a broadcast counts as 1. It wraps from all-ones to 0.
- Reset (at any time, including mid-transfer): all full_k <= 0, data_k <= 0, xfer_count <= 0. Held words are discarded. Reset values: valid_* = 0, out_* = 0, in_ready = 0, xfer_count = 0.
- No combinational path from in_data to the outputs. There is a combinational path from ready_k to in_ready; consumers must not derive ready_k from in_ready.

Decomposition:
- Shared package holds:
  - WIDTH default.
  - Channel code constants CH_A = 2'b00, CH_B = 2'b01, CH_C = 2'b10, CH_D = 2'b11, shared with the 4:1 mux select encoding.
- One sub-module, demux_slot: a one-entry holding register with load/ready/valid/can_take logic. Instantiated four times.
- Top level contains the select decode, broadcast gating, in_ready and the counter.

Test Plan:
- Reset then idle → valid_* = 0, out_* = 0, xfer_count = 0. in_ready = 0 during rst and 1 after.
- select = 10, in_data = 16'hA5A5, in_valid pulse, ready_C = 1 → next cycle valid_C = 1, out_C = 16'hA5A5, other valids 0, xfer_count = 1.
- ready_B = 0; send 16'h1111 then 16'h2222 to B → first accepted, second stalls with in_ready = 0. out_B holds 16'h1111. Raise ready_B → 16'h2222 loads the same cycle with no valid gap.
- B full and stalled; send 16'h3333 to D → accepted, out_D = 16'h3333. Shows no head-of-line blocking across channels.
- bcast = 1, in_data = 16'hBEEF, C full and stalled → in_ready = 0 and no channel loads. Release ready_C → all four show 16'hBEEF, xfer_count += 1.
- Assert rst while A and D are full → valids clear next edge, xfer_count = 0. Preload xfer_count to 16'hFFFF, then one accept → wraps to 0.

Source files
------------

// File: rtl/demux_4_pkg.sv
`default_nettype none
// ============================================================================
// demux_4_pkg : shared widths and channel codes for demux_4 and the 4:1 mux
// Rev 1.0
// ============================================================================
package demux_4_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 16;

  // Channel codes are shared with the registered 4:1 mux select encoding.
  localparam logic [1:0] CH_A = 2'b00;
  localparam logic [1:0] CH_B = 2'b01;
  localparam logic [1:0] CH_C = 2'b10;
  localparam logic [1:0] CH_D = 2'b11;

  function automatic logic [3:0] ch_onehot(input logic [1:0] sel);
    logic [3:0] oh;
    oh = 4'b0000;
    case (sel)
      CH_A:    oh = 4'b0001;
      CH_B:    oh = 4'b0010;
      CH_C:    oh = 4'b0100;
      CH_D:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
// demux_slot : one-entry holding register with valid/ready handshake
// Rev 1.0
// ============================================================================
module demux_slot
  import demux_4_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [0:WIDTH-1] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [0:WIDTH-1] data,
  output logic             can_take
);

  logic             r_full;
  logic [0:WIDTH-1] r_data;

  // A load takes priority over a drain, so refill-while-draining leaves no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (load) begin
      r_full <= 1'b1;
      r_data <= load_data;
    end else if (ready) begin
      r_full <= 1'b0;
    end
  end

  assign valid    = r_full;
  assign data     = r_data;
  assign can_take = !r_full || ready;

endmodule
`default_nettype wire

// File: rtl/demux_4.sv
`default_nettype none
// ============================================================================
// demux_4 : registered 1-to-4 demultiplexer with broadcast and per-channel
//           holding registers so one stalled consumer blocks only its channel
// Rev 1.0
// ============================================================================
module demux_4
  import demux_4_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:WIDTH-1] in_data,
  input  logic             in_valid,
  input  logic [1:0]       select,
  input  logic             bcast,
  output logic             in_ready,
  output logic [0:WIDTH-1] out_A,
  output logic [0:WIDTH-1] out_B,
  output logic [0:WIDTH-1] out_C,
  output logic [0:WIDTH-1] out_D,
  output logic             valid_A,
  output logic             valid_B,
  output logic             valid_C,
  output logic             valid_D,
  input  logic             ready_A,
  input  logic             ready_B,
  input  logic             ready_C,
  input  logic             ready_D,
  output logic [CNT_W-1:0] xfer_count
);

  logic [3:0]       w_ready;
  logic [3:0]       w_can_take;
  logic [3:0]       w_valid;
  logic [3:0]       w_target;
  logic [3:0]       w_load;
  logic             w_accept;
  logic [0:WIDTH-1] w_data [4];
  logic [CNT_W-1:0] r_count;

  assign w_ready  = {ready_D, ready_C, ready_B, ready_A};
  assign w_target = bcast ? 4'b1111 : ch_onehot(select);

  // Broadcast is all-or-nothing: every channel must be able to take the word.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      in_ready = bcast ? (&w_can_take) : w_can_take[select];
    end
  end

  assign w_accept = in_valid && in_ready;
  assign w_load   = {4{w_accept}} & w_target;

  for (genvar k = 0; k < 4; k++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (w_load[k]),
      .load_data (in_data),
      .ready     (w_ready[k]),
      .valid     (w_valid[k]),
      .data      (w_data[k]),
      .can_take  (w_can_take[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_A      = w_data[0];
  assign out_B      = w_data[1];
  assign out_C      = w_data[2];
  assign out_D      = w_data[3];
  assign valid_A    = w_valid[0];
  assign valid_B    = w_valid[1];
  assign valid_C    = w_valid[2];
  assign valid_D    = w_valid[3];
  assign xfer_count = r_count;

endmodule
`default_nettype wire
